multiplier: RTL and testbench

//   Fully pipelined WIDTH x WIDTH integer multiplier producing a 2*WIDTH-bit product.

---
 rtl/multiplier.sv | 143 ++++++++++++++
 tb/tb_multiplier.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// multiplier: fully pipelined WIDTH x WIDTH integer multiplier, 2*WIDTH-bit product,
// fixed latency of 3 rising edges, one operand pair accepted every clock.
//   S1: register operands
//   S2: register four half-width partial products (one multiply stage each)
//   S3: register the recombined full-width product on pdt
// Configuration macro: MULT_SIGNED_EN
//   undefined -> unsigned operands and product (default)
//   defined   -> two's complement operands and product
// WIDTH must be even and >= 4.
module multiplier #(
  parameter int WIDTH = 40
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   pdt
);

  localparam int H  = WIDTH / 2;   // half-operand width
  localparam int PW = 2 * H;       // partial-product width
  localparam int OW = 2 * WIDTH;   // product width

`ifdef MULT_SIGNED_EN
  // Upper halves carry the operand sign; lower halves are always magnitudes.
  localparam logic SGN = 1'b1;
`else
  localparam logic SGN = 1'b0;
`endif

  // Multiply two (H+1)-bit signed values. Each operand is a half widened by one
  // bit (zero for unsigned halves, sign for signed halves), so one helper serves
  // the unsigned, signed and mixed-sign partial products. Every exact result fits
  // in PW bits of two's complement, so the low PW bits are the partial product.
  function automatic logic [PW-1:0] half_mul(input logic [H:0] x, input logic [H:0] y);
    logic [2*H+1:0] xe;
    logic [2*H+1:0] ye;
    logic [2*H+1:0] pr;
    xe = {{(H+1){x[H]}}, x};
    ye = {{(H+1){y[H]}}, y};
    pr = xe * ye;
    return pr[PW-1:0];
  endfunction

  // Widen a partial product to the full product width, sign-extending only when
  // the term is signed.
  function automatic logic [OW-1:0] widen(input logic [PW-1:0] p, input logic s);
    return {{(OW-PW){s & p[PW-1]}}, p};
  endfunction

  // S1 operand registers
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // S2 partial-product registers
  logic [PW-1:0] r_pll;
  logic [PW-1:0] r_plh;
  logic [PW-1:0] r_phl;
  logic [PW-1:0] r_phh;

  // S3 product register
  logic [OW-1:0] r_pdt;

  // Half splits of the registered operands, extended by one bit
  logic [H:0] w_al_x;
  logic [H:0] w_ah_x;
  logic [H:0] w_bl_x;
  logic [H:0] w_bh_x;

  // Partial products feeding S2
  logic [PW-1:0] w_pll;
  logic [PW-1:0] w_plh;
  logic [PW-1:0] w_phl;
  logic [PW-1:0] w_phh;

  // Recombined product feeding S3
  logic [OW-1:0] w_sum;

  // Split registered operands into halves; only the high halves may be signed.
  always_comb begin
    w_al_x = {1'b0, r_a[H-1:0]};
    w_bl_x = {1'b0, r_b[H-1:0]};
    w_ah_x = {SGN & r_a[WIDTH-1], r_a[WIDTH-1:H]};
    w_bh_x = {SGN & r_b[WIDTH-1], r_b[WIDTH-1:H]};
  end

  // Form the four half-width partial products.
  always_comb begin
    w_pll = half_mul(w_al_x, w_bl_x);
    w_plh = half_mul(w_al_x, w_bh_x);
    w_phl = half_mul(w_ah_x, w_bl_x);
    w_phh = half_mul(w_ah_x, w_bh_x);
  end

  // Recombine at full width. pLL is always unsigned; the cross terms and pHH are
  // signed in the signed build. Summing cross terms after widening keeps the
  // middle-sum carry into bit 2H+1. Wrap at OW bits is exact because the true
  // product always fits.
  always_comb begin
    w_sum = widen(r_pll, 1'b0)
          + (widen(r_plh, SGN) << H)
          + (widen(r_phl, SGN) << H)
          + (widen(r_phh, SGN) << PW);
  end

  // S1: capture the operand pair presented this cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_a <= {WIDTH{1'b0}};
      r_b <= {WIDTH{1'b0}};
    end else begin
      r_a <= a;
      r_b <= b;
    end
  end

  // S2: register the partial products of the S1 pair.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pll <= {PW{1'b0}};
      r_plh <= {PW{1'b0}};
      r_phl <= {PW{1'b0}};
      r_phh <= {PW{1'b0}};
    end else begin
      r_pll <= w_pll;
      r_plh <= w_plh;
      r_phl <= w_phl;
      r_phh <= w_phh;
    end
  end

  // S3: register the final product so pdt is glitch-free for a full cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pdt <= {OW{1'b0}};
    end else begin
      r_pdt <= w_sum;
    end
  end

  assign pdt = r_pdt;

endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: self-checking bench for multiplier (WIDTH=40). Expected products
// come from plain full-width arithmetic on the applied operands, delayed through a
// queue by the pipeline latency. Honours MULT_SIGNED_EN like the design.
module tb_multiplier;

  localparam int W  = 40;
  localparam int OW = 2 * W;

  logic          clk_in;
  logic          rst_in;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [OW-1:0] pdt;

  int n_vec;
  int n_miss;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_v;

  multiplier #(.WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .a      (a),
    .b      (b),
    .pdt    (pdt)
  );

  // 10 ns clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Golden product of one operand pair, exact at full width.
  function automatic logic [OW-1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [OW-1:0] xe;
    logic [OW-1:0] ye;
`ifdef MULT_SIGNED_EN
    xe = {{W{x[W-1]}}, x};
    ye = {{W{y[W-1]}}, y};
`else
    xe = {{W{1'b0}}, x};
    ye = {{W{1'b0}}, y};
`endif
    return xe * ye;
  endfunction

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // After (re)start the pipeline holds zeros: the first two edges show 0.
  task automatic model_restart();
    exp_q.delete();
    exp_q.push_back({OW{1'b0}});
    exp_q.push_back({OW{1'b0}});
  endtask

  // Present a pair, clock it in, then check pdt 1 ns after the edge.
  task automatic step(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    @(posedge clk_in);
    exp_q.push_back(golden(x, y));
    exp_v = exp_q.pop_front();
    #1;
    check(tag, pdt, exp_v);
  endtask

  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [W-1:0] one_w;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    one_w  = {{(W-1){1'b0}}, 1'b1};
    a      = {W{1'b0}};
    b      = {W{1'b0}};
    rst_in = 1'b0;

    // Asynchronous reset, applied between edges
    #1 rst_in = 1'b1;
    #1 check("reset_async", pdt, {OW{1'b0}});
    @(posedge clk_in);
    a = {W{1'b1}};
    b = {W{1'b1}};
    @(posedge clk_in);
    #1 check("reset_hold", pdt, {OW{1'b0}});
    @(negedge clk_in);
    rst_in = 1'b0;
    model_restart();
    #1;

    // Single pair followed by idle zeros; product appears on the 3rd edge
    step("one_pair", 40'd1, 40'd2);
    step("lat_e2", 40'd0, 40'd0);
    step("lat_e3", 40'd0, 40'd0);
    step("lat_e4", 40'd0, 40'd0);

    // Back-to-back stream
    for (int i = 0; i < 5; i++) begin
      step("b2b", 40'(3 + 2 * i), 40'(4 + 2 * i));
    end
    for (int i = 0; i < 3; i++) step("b2b_drain", 40'd0, 40'd0);

    // Boundary operands
    step("max_max", {W{1'b1}}, {W{1'b1}});
    step("cross_carry", one_w << 20, one_w << 20);
    step("min_neg", one_w << 39, one_w << 39);
    step("pos_x_neg", (one_w << 39) - one_w, one_w << 39);
    step("neg1_neg1", {W{1'b1}}, {W{1'b1}});
    step("neg1_x5", {W{1'b1}}, 40'd5);
    step("lowhalf_max", 40'h00_000F_FFFF, 40'hFF_FFF0_0000);
    step("zero_x_max", 40'd0, {W{1'b1}});
    for (int i = 0; i < 3; i++) step("bound_drain", 40'd0, 40'd0);

    // Mid-stream reset between edges: everything in flight is discarded
    step("pre_rst", 40'd123456, 40'd654321);
    step("pre_rst", 40'd777, 40'd999);
    #2 rst_in = 1'b1;
    #1 check("midrst_async", pdt, {OW{1'b0}});
    @(posedge clk_in);
    #1 check("midrst_hold", pdt, {OW{1'b0}});
    @(negedge clk_in);
    rst_in = 1'b0;
    model_restart();
    #1;
    step("post_rst_e1", 40'd11, 40'd13);
    step("post_rst_e2", 40'd17, 40'd19);
    step("post_rst_e3", 40'd0, 40'd0);
    step("post_rst_e4", 40'd0, 40'd0);

    // Random stream
    for (int i = 0; i < 10000; i++) begin
      ra = {8'($urandom), 32'($urandom)};
      rb = {8'($urandom), 32'($urandom)};
      if (i % 97 == 0) ra = {W{1'b1}};
      if (i % 89 == 0) rb = one_w << 39;
      step("random", ra, rb);
    end
    for (int i = 0; i < 3; i++) step("rand_drain", 40'd0, 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
